counter_bcd_ctrl: RTL and testbench

//  Sequencer for the score counter and its decimal display datapath. Conditions the raw push button
//  (sync, debounce, press edge, hold auto-repeat), steps a 0..MAX_COUNT wrap counter, and runs an

---
 rtl/counter_bcd_ctrl_if.sv | 23 ++
 rtl/counter_bcd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_counter_bcd_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_bcd_ctrl_if.sv
// Button, clear and display-digit signals shared between the score sequencer and its user.
// The master drives the button and clear; the slave (the sequencer) drives the rest.
interface counter_bcd_ctrl_if;
    logic       nPBTON;
    logic       clr;
    logic [9:0] count;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       digits_valid;
    logic       busy;
    logic       inc_pulse;

    modport master (
        output nPBTON, clr,
        input  count, units, tens, hundreds, digits_valid, busy, inc_pulse
    );

    modport slave (
        input  nPBTON, clr,
        output count, units, tens, hundreds, digits_valid, busy, inc_pulse
    );
endinterface

// File: rtl/counter_bcd_ctrl.sv
// Score counter sequencer: button conditioning with auto-repeat, a 0..MAX_COUNT wrap counter,
// and an iterative double-dabble converter that publishes BCD digits atomically.
module counter_bcd_ctrl #(
    parameter int unsigned FPGAFREQ         = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC     = FPGAFREQ / 100,
    parameter int unsigned REPEAT_DELAY_CYC = FPGAFREQ / 2,
    parameter int unsigned REPEAT_RATE_CYC  = FPGAFREQ / 10,
    parameter int unsigned MAX_COUNT        = 999
) (
    input  logic                CLK,
    input  logic                nRST,
    counter_bcd_ctrl_if.slave   bus
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TmrMax = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                     REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned TmW    = $clog2(TmrMax + 1);

    typedef enum logic [1:0] {BtnIdle, BtnHold, BtnRepeat} btn_state_e;
    typedef enum logic [1:0] {CIdle, CLoad, CShift, CDone} conv_state_e;

    logic [1:0]     sync_q;
    logic           press_raw;
    logic           db_q, db_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    btn_state_e     btn_q, btn_d;
    logic [TmW-1:0] tmr_q, tmr_d;
    logic           inc;
    logic [9:0]     count_q, count_d;
    logic           upd;
    conv_state_e    conv_q, conv_d;
    logic [9:0]     sh_q, sh_d;
    logic [11:0]    bcd_q, bcd_d, bcd_adj;
    logic [3:0]     iter_q, iter_d;
    logic [11:0]    dig_q, dig_d;
    logic           dv_q, dv_d;
    logic           pend_q, pend_d;
    logic           latch;

    assign press_raw = ~sync_q[1];

    // Level only flips after DEBOUNCE_CYC consecutive samples disagreeing with it.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (press_raw != db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        btn_d = btn_q;
        tmr_d = tmr_q;
        inc   = 1'b0;
        case (btn_q)
            BtnIdle: begin
                if (db_q) begin
                    inc   = 1'b1;
                    btn_d = BtnHold;
                    tmr_d = '0;
                end
            end
            BtnHold: begin
                if (!db_q) begin
                    btn_d = BtnIdle;
                end else if (tmr_q == TmW'(REPEAT_DELAY_CYC - 1)) begin
                    inc   = 1'b1;
                    btn_d = BtnRepeat;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            BtnRepeat: begin
                if (!db_q) begin
                    btn_d = BtnIdle;
                end else if (tmr_q == TmW'(REPEAT_RATE_CYC - 1)) begin
                    inc   = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: btn_d = BtnIdle;
        endcase
    end

    always_comb begin
        upd     = bus.clr | inc;
        count_d = count_q;
        if (bus.clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q == 10'(MAX_COUNT)) ? 10'd0 : count_q + 10'd1;
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        conv_d = conv_q;
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        dig_d  = dig_q;
        dv_d   = 1'b0;
        latch  = 1'b0;
        case (conv_q)
            CIdle: begin
                if (pend_q) latch = 1'b1;
            end
            CLoad: begin
                {bcd_d, sh_d} = {bcd_adj[10:0], sh_q, 1'b0};
                iter_d        = 4'd1;
                conv_d        = CShift;
            end
            CShift: begin
                {bcd_d, sh_d} = {bcd_adj[10:0], sh_q, 1'b0};
                iter_d        = iter_q + 4'd1;
                if (iter_q == 4'd9) conv_d = CDone;
            end
            CDone: begin
                dig_d = bcd_q;
                dv_d  = 1'b1;
                if (pend_q) begin
                    latch = 1'b1;
                end else begin
                    conv_d = CIdle;
                end
            end
            default: conv_d = CIdle;
        endcase
        if (latch) begin
            conv_d = CLoad;
            sh_d   = count_q;
            bcd_d  = '0;
            iter_d = '0;
        end
        // An update on the latching edge is not captured, so it must keep pend set.
        pend_d = upd | (pend_q & ~latch);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q   <= 2'b11;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            btn_q    <= BtnIdle;
            tmr_q    <= '0;
            count_q  <= '0;
            conv_q   <= CIdle;
            sh_q     <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            dig_q    <= '0;
            dv_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], bus.nPBTON};
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            btn_q    <= btn_d;
            tmr_q    <= tmr_d;
            count_q  <= count_d;
            conv_q   <= conv_d;
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            dig_q    <= dig_d;
            dv_q     <= dv_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.count        = count_q;
    assign bus.units        = dig_q[3:0];
    assign bus.tens         = dig_q[7:4];
    assign bus.hundreds     = dig_q[11:8];
    assign bus.digits_valid = dv_q;
    assign bus.busy         = (conv_q != CIdle);
    assign bus.inc_pulse    = inc;

endmodule

// File: tb/tb_counter_bcd_ctrl.sv
// Directed bench for counter_bcd_ctrl with a cycle-level scoreboard of the counter and converter.
module tb_counter_bcd_ctrl;

    localparam int MAX = 999;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    counter_bcd_ctrl_if bus ();

    counter_bcd_ctrl #(
        .FPGAFREQ        (1000),
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC (8),
        .MAX_COUNT       (MAX)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: each negedge accounts for the preceding rising edge, using the
    // inc/clr values sampled one negedge earlier (what that edge saw).
    int         m_count, m_phase, m_latched, pulses;
    bit         m_pend, m_dv, m_latch, inc_s, clr_s, mon_en;
    logic [11:0] m_dig;

    always @(negedge CLK) begin
        if (!nRST) begin
            m_count = 0; m_phase = 0; m_latched = 0; m_pend = 0; m_dig = '0;
            inc_s = 0; clr_s = 0;
        end else begin
            m_dv = 0;
            m_latch = 0;
            if (m_phase == 0) begin
                if (m_pend) m_latch = 1;
            end else if (m_phase < 11) begin
                m_phase++;
            end else begin
                m_dig = to_bcd(m_latched);
                m_dv  = 1;
                if (m_pend) m_latch = 1;
                else m_phase = 0;
            end
            if (m_latch) begin
                m_latched = m_count; m_pend = 0; m_phase = 1;
            end
            if (clr_s) begin
                m_count = 0; m_pend = 1;
            end else if (inc_s) begin
                m_count = (m_count == MAX) ? 0 : m_count + 1; m_pend = 1;
            end
            if (mon_en) begin
                check("sb_count", bus.count, m_count);
                check("sb_digits", {bus.hundreds, bus.tens, bus.units}, m_dig);
                check("sb_digits_valid", bus.digits_valid, m_dv);
                check("sb_busy", bus.busy, (m_phase != 0));
            end
            if (bus.inc_pulse === 1'b1) pulses++;
            inc_s = bus.inc_pulse;
            clr_s = bus.clr;
        end
    end

    task automatic hold_until(input int target, input int budget);
        bit done = 0;
        bus.nPBTON = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (bus.inc_pulse && bus.count == 10'(target - 1)) begin
                bus.nPBTON = 1'b1;
                done = 1;
            end
        end
        bus.nPBTON = 1'b1;
        check("hold_target_reached", done, 1);
        repeat (30) tick();
        check("hold_count", bus.count, target);
        check("hold_digits", {bus.hundreds, bus.tens, bus.units}, to_bcd(target));
        check("hold_idle", bus.busy, 0);
    endtask

    task automatic press_measure(input int exp_count);
        bit seen = 0;
        int lat  = -1;
        bus.nPBTON = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus.count == 10'(exp_count)) seen = 1;
        end
        bus.nPBTON = 1'b1;
        check("press_count_change", seen, 1);
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            tick();
            if (bus.digits_valid) lat = j;
        end
        check("press_strobe_latency", lat, 12);
        repeat (20) tick();
        check("press_count", bus.count, exp_count);
        check("press_digits", {bus.hundreds, bus.tens, bus.units}, to_bcd(exp_count));
    endtask

    task automatic strobe_latency(input string tag);
        int lat = -1;
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            tick();
            if (bus.digits_valid) lat = j;
        end
        check(tag, lat, 12);
    endtask

    initial begin
        int  p1, p2, np;
        bit  hit;
        bus.nPBTON = 1'b1;
        bus.clr    = 1'b0;
        mon_en     = 0;
        pulses     = 0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        mon_en = 1;

        // Idle after reset
        repeat (20) tick();
        check("rst_count", bus.count, 0);
        check("rst_digits", {bus.hundreds, bus.tens, bus.units}, 12'h000);
        check("rst_pulses", pulses, 0);
        check("rst_valid", bus.digits_valid, 0);
        check("rst_busy", bus.busy, 0);

        // Three-cycle glitch is rejected
        bus.nPBTON = 1'b0;
        repeat (3) tick();
        bus.nPBTON = 1'b1;
        repeat (10) tick();
        check("glitch_pulses", pulses, 0);

        // Long hold: first pulse after sync+debounce, first repeat 20 cycles later
        p1 = -1; p2 = -1; np = 0;
        bus.nPBTON = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            tick();
            if (bus.inc_pulse) begin
                np++;
                if (p1 < 0) p1 = i;
                else if (p2 < 0) p2 = i;
            end
        end
        bus.nPBTON = 1'b1;
        check("first_pulse_at", p1, 6);
        check("repeat_gap", p2 - p1, 20);
        check("hold_pulses", np, 2);
        repeat (30) tick();
        check("release_pulses", pulses, 2);
        check("hold_count2", bus.count, 2);
        check("hold_digits002", {bus.hundreds, bus.tens, bus.units}, 12'h002);

        // Wrap boundary
        hold_until(998, 9000);
        press_measure(999);
        press_measure(0);

        // Repeats faster than conversion: updates collapse, digits stay consistent
        hold_until(40, 600);

        // clr together with inc_pulse at 57
        hold_until(57, 600);
        hit = 0;
        bus.nPBTON = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (bus.inc_pulse) begin
                bus.clr = 1'b1;
                hit = 1;
            end
        end
        check("clr_inc_pulse_seen", hit, 1);
        tick();
        bus.clr    = 1'b0;
        bus.nPBTON = 1'b1;
        check("clr_priority_count", bus.count, 0);
        strobe_latency("clr_strobe_latency");
        check("clr_digits", {bus.hundreds, bus.tens, bus.units}, 12'h000);
        repeat (20) tick();

        // clr at zero still re-publishes
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        strobe_latency("clr0_strobe_latency");
        repeat (10) tick();

        // Reset in the middle of a conversion
        hit = 0;
        bus.nPBTON = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (bus.count == 10'd1) hit = 1;
        end
        bus.nPBTON = 1'b1;
        check("pre_rst_press", hit, 1);
        repeat (5) tick();
        check("pre_rst_busy", bus.busy, 1);
        nRST = 1'b0;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_digits", {bus.hundreds, bus.tens, bus.units}, 12'h000);
        check("arst_valid", bus.digits_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_inc", bus.inc_pulse, 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (5) tick();
        press_measure(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
